// File: rtl/div_4bit_seq.sv
// Sequential restoring unsigned divider: one quotient bit per clock,
// quotient/remainder returned with a one-cycle done pulse.
module div_4bit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic             q_bit_s;

    // The remainder always stays below the divisor, so WIDTH bits hold it;
    // only the shifted value and the trial difference need the extra sign bit.
    assign rem_sh_s = {rem_r, dvd_r[WIDTH-1]};
    assign trial_s  = rem_sh_s - {1'b0, dsr_r};
    assign q_bit_s  = ~trial_s[WIDTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (B == {WIDTH{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(0)) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dsr_r       <= {WIDTH{1'b0}};
            cnt_r       <= CW'(0);
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= {WIDTH{1'b0}};
            R           <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dvd_r <= A;
                        dsr_r <= B;
                        rem_r <= {WIDTH{1'b0}};
                        cnt_r <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    rem_r <= q_bit_s ? trial_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
                    dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
                    if (cnt_r == CW'(0)) begin
                        busy <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (dsr_r == {WIDTH{1'b0}}) begin
                        Q           <= {WIDTH{1'b1}};
                        R           <= dvd_r;
                        div_by_zero <= 1'b1;
                    end else begin
                        Q           <= dvd_r;
                        R           <= rem_r;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_4bit_seq.sv
// Scoreboard-based bench for div_4bit_seq: expected results are queued when an
// operation is started and compared when done pulses.
module tb_div_4bit_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];

    div_4bit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 4'hF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Present a start pulse for exactly one accepting edge, then scramble operands.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        if (push) sb.push_back(model(a, b));
        @(posedge clk);
        #1 start = 1'b0;
        A = 4'($urandom); B = 4'($urandom);
    endtask

    // lat = index of the first post-edge sample showing done (-1 on timeout).
    task automatic wait_done(output int lat, output logic [15:0] hist);
        lat = -1; hist = 16'h0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hist[k] = busy;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_Q got=%0d exp=0", Q); end
        checks++; if (R !== 4'd0) begin errors++; $display("FAIL reset_R got=%0d exp=0", R); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_patterns();
        logic [W-1:0] ta [5] = '{4'd13, 4'd15, 4'd3, 4'd0, 4'd8};
        logic [W-1:0] tb [5] = '{4'd4,  4'd1,  4'd9, 4'd7, 4'd2};
        int lat; logic [15:0] hist; exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_start(ta[i], tb[i], 1'b1);
            wait_done(lat, hist);
            e = sb.pop_front();
            checks++; if (lat !== 5) begin errors++; $display("FAIL pat%0d_latency got=%0d exp=5", i, lat); end
            checks++; if (hist !== 16'h000F) begin errors++; $display("FAIL pat%0d_busy got=%h exp=000f", i, hist); end
            checks++; if (Q !== e.q) begin errors++; $display("FAIL pat%0d_Q got=%0d exp=%0d", i, Q, e.q); end
            checks++; if (R !== e.r) begin errors++; $display("FAIL pat%0d_R got=%0d exp=%0d", i, R, e.r); end
            checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL pat%0d_dbz got=%b exp=0", i, div_by_zero); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL pat%0d_done_width got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [15:0] hist; exp_t e;
        drive_start(4'd7, 4'd0, 1'b1);
        wait_done(lat, hist);
        e = sb.pop_front();
        checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
        checks++; if (hist !== 16'h0001) begin errors++; $display("FAIL dbz_busy got=%h exp=0001", hist); end
        checks++; if (Q !== e.q) begin errors++; $display("FAIL dbz_Q got=%0d exp=%0d", Q, e.q); end
        checks++; if (R !== e.r) begin errors++; $display("FAIL dbz_R got=%0d exp=%0d", R, e.r); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        @(negedge clk);
        checks++; if (Q !== e.q || div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold got=%0d/%b exp=%0d/1", Q, div_by_zero, e.q); end
        drive_start(4'd8, 4'd2, 1'b1);
        wait_done(lat, hist);
        e = sb.pop_front();
        checks++; if (lat !== 5) begin errors++; $display("FAIL dbz_next_latency got=%0d exp=5", lat); end
        checks++; if (Q !== e.q || R !== e.r) begin errors++; $display("FAIL dbz_next_QR got=%0d/%0d exp=%0d/%0d", Q, R, e.q, e.r); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_next_flag got=%b exp=0", div_by_zero); end
    endtask

    task automatic test_ignore_start();
        int lat; int extra; logic [15:0] hist; exp_t e;
        drive_start(4'd12, 4'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        A = 4'd9; B = 4'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, hist);
        e = sb.pop_front();
        checks++; if (lat !== 3) begin errors++; $display("FAIL ign_latency got=%0d exp=3", lat); end
        checks++; if (Q !== e.q || R !== e.r) begin errors++; $display("FAIL ign_QR got=%0d/%0d exp=%0d/%0d", Q, R, e.q, e.r); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat; int seen; logic [15:0] hist; exp_t e;
        drive_start(4'd14, 4'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got=%b%b exp=00", busy, done); end
        checks++; if (Q !== 4'd0 || R !== 4'd0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_data got=%0d/%0d/%b exp=0/0/0", Q, R, div_by_zero); end
        seen = 0;
        repeat (2) begin @(negedge clk); if (done) seen++; end
        rst = 1'b0;
        repeat (8) begin @(negedge clk); if (done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", seen); end
        drive_start(4'd14, 4'd3, 1'b1);
        wait_done(lat, hist);
        e = sb.pop_front();
        checks++; if (lat !== 5) begin errors++; $display("FAIL rmid_latency got=%0d exp=5", lat); end
        checks++; if (Q !== e.q || R !== e.r) begin errors++; $display("FAIL rmid_QR got=%0d/%0d exp=%0d/%0d", Q, R, e.q, e.r); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] hist; exp_t e;
        @(negedge clk);
        A = 4'd6; B = 4'd2; start = 1'b1;
        sb.push_back(model(4'd6, 4'd2));
        @(posedge clk);
        #1 A = 4'd9; B = 4'd4;
        sb.push_back(model(4'd9, 4'd4));
        wait_done(lat, hist);
        e = sb.pop_front();
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b1_latency got=%0d exp=5", lat); end
        checks++; if (Q !== e.q || R !== e.r) begin errors++; $display("FAIL b2b1_QR got=%0d/%0d exp=%0d/%0d", Q, R, e.q, e.r); end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, hist);
        e = sb.pop_front();
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b2_spacing got=%0d exp=5", lat); end
        checks++; if (hist !== 16'h000F) begin errors++; $display("FAIL b2b2_busy got=%h exp=000f", hist); end
        checks++; if (Q !== e.q || R !== e.r) begin errors++; $display("FAIL b2b2_QR got=%0d/%0d exp=%0d/%0d", Q, R, e.q, e.r); end
    endtask

    task automatic test_random();
        int lat; int exp_lat; logic [15:0] hist; exp_t e;
        logic [W-1:0] a; logic [W-1:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = 4'($urandom_range(15, 0));
            b = 4'($urandom_range(15, 0));
            exp_lat = (b == 4'd0) ? 1 : 5;
            drive_start(a, b, 1'b1);
            wait_done(lat, hist);
            e = sb.pop_front();
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency a=%0d b=%0d got=%0d exp=%0d", i, a, b, lat, exp_lat); end
            checks++; if (Q !== e.q || R !== e.r || div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL rnd%0d_result a=%0d b=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, a, b, Q, R, div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
        test_reset();
        test_patterns();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
